// File: rtl/x2050_hreg_sched.sv
// rtl/x2050_hreg_sched.sv - H register load-slot scheduler: microcode owns advance cycles, requesters share idle ones
module x2050_hreg_sched #(
  parameter int MAX_WAIT = 4,
  parameter int WCW      = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ros_advance,
  input  logic [4:0] i_tr,
  input  logic [4:0] i_al,
  input  logic [2:0] i_req,
  output logic [2:0] o_ack,
  output logic       o_h_adv,
  output logic [4:0] o_h_tr,
  output logic [4:0] o_h_al,
  output logic       o_ros_hold,
  output logic       o_busy
);

  // Load-control codes injected on behalf of each requester; zero is a no-op code.
  localparam logic [4:0] AL_IAR_SAVE = 5'd6;
  localparam logic [4:0] TR_T_LOAD   = 5'd20;
  localparam logic [4:0] AL_T0_NIB   = 5'd24;

  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [1:0]     rr;        // index of the most recently served requester
  logic [2:0]     grant;     // one-hot requester owning the pending write
  logic [WCW-1:0] wait_cnt;  // slots lost to microcode while in WRITE
  logic [2:0]     pick;
  logic [1:0]     grant_idx;
  logic [WCW-1:0] wait_inc;

  // Round-robin search starting one past the last served index.
  always_comb begin
    pick = 3'b000;
    case (rr)
      2'd0: begin
        if      (i_req[1]) pick = 3'b010;
        else if (i_req[2]) pick = 3'b100;
        else if (i_req[0]) pick = 3'b001;
      end
      2'd1: begin
        if      (i_req[2]) pick = 3'b100;
        else if (i_req[0]) pick = 3'b001;
        else if (i_req[1]) pick = 3'b010;
      end
      default: begin
        if      (i_req[0]) pick = 3'b001;
        else if (i_req[1]) pick = 3'b010;
        else if (i_req[2]) pick = 3'b100;
      end
    endcase
  end

  // Encode the held grant back to an index for the round-robin pointer.
  always_comb begin
    grant_idx = 2'd2;
    if      (grant[0]) grant_idx = 2'd0;
    else if (grant[1]) grant_idx = 2'd1;
  end

  // Saturating next value of the lost-slot counter.
  always_comb begin
    wait_inc = wait_cnt;
    if (wait_cnt < WAIT_MAX) wait_inc = wait_cnt + 1'b1;
  end

  // Scheduler FSM with registered ack and hold outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      rr         <= 2'd2;
      grant      <= 3'b000;
      wait_cnt   <= '0;
      o_ack      <= 3'b000;
      o_ros_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_ack <= 3'b000;
          if (|i_req) begin
            grant    <= pick;
            wait_cnt <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (!i_ros_advance) begin
            // Injected write happens in this cycle; report it next cycle.
            o_ack <= grant;
            state <= DONE;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_MAX) o_ros_hold <= 1'b1;
          end
        end
        DONE: begin
          o_ack      <= 3'b000;
          rr         <= grant_idx;
          o_ros_hold <= 1'b0;
          wait_cnt   <= '0;
          state      <= IDLE;
        end
        default: begin
          o_ack      <= 3'b000;
          o_ros_hold <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // H register control mux: microcode first, then the injected write, else quiet.
  always_comb begin
    o_h_adv = 1'b0;
    o_h_tr  = 5'd0;
    o_h_al  = 5'd0;
    if (i_ros_advance) begin
      o_h_adv = 1'b1;
      o_h_tr  = i_tr;
      o_h_al  = i_al;
    end else if (state == WRITE) begin
      o_h_adv = 1'b1;
      if (grant[0])      o_h_al = AL_IAR_SAVE;
      else if (grant[1]) o_h_tr = TR_T_LOAD;
      else if (grant[2]) o_h_al = AL_T0_NIB;
    end
  end

  assign o_busy = (state != IDLE);

endmodule
